div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst, both sampled on the rising edge of clk.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  request a divide; sampled only in IDLE.
REQ-005 SHALL have port a  input  32  dividend.
REQ-006 SHALL have port b  input  32  divisor.
REQ-007 SHALL have port op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M funct3[1:0]).
REQ-008 SHALL have port busy  output  1  high while an operation is in flight (not IDLE).
REQ-009 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-010 SHALL have port res  output  32  quotient or remainder per op.
REQ-011 SHALL have port zero  output  1  high iff res == 0 (same meaning as ALU zero flag).

Function
REQ-012 SHALL implement states IDLE, RUN, FIX, DONE; IDLE->RUN on start; RUN->FIX after 32 iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-013 SHALL capture a, b, op in the start cycle T; later input changes have no effect on the operation.
REQ-014 SHALL perform restoring division on 32-bit magnitudes, one quotient bit per cycle in RUN (cycles T+1..T+32).
REQ-015 SHALL, for DIV/REM, take magnitudes of two's-complement operands; DIVU/REMU operands are unsigned.
REQ-016 SHALL in FIX negate the quotient iff signed op, b != 0 and sign(a) != sign(b); negate the remainder iff signed op and a negative.
REQ-017 SHALL assert done for exactly one cycle at T+34 (nominal latency 34), with busy low in that same cycle.
REQ-018 SHALL hold res and zero stable from the done cycle until the next accepted start; res is not updated during RUN/FIX.
REQ-019 SHALL ignore start while busy is high; no queuing.
REQ-020 SHALL accept a new start in the cycle immediately after done (back-to-back throughput 35 cycles).
REQ-021 SHALL, when b == 0, return quotient 0xFFFFFFFF and remainder a, for both signed and unsigned ops.
REQ-022 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, return quotient 0x80000000 and remainder 0 (no trap, no flag).

Reset
REQ-023 SHALL, with rst high at a rising edge, enter IDLE with busy=0, done=0, res=0, zero=1.
REQ-024 SHALL abort an in-flight operation on reset mid-RUN/FIX/DONE; no done pulse is produced for it.
REQ-025 SHALL give rst priority over start in the same cycle.

Configuration
REQ-026 SHALL support macro DIV_UNIT_EARLY_OUT_EN.
REQ-027 SHALL, with DIV_UNIT_EARLY_OUT_EN defined, bypass RUN when b == 0 or |a| < |b| (magnitudes), go IDLE->FIX->DONE, and pulse done at T+2 with results per REQ-016/REQ-021.
REQ-028 SHALL, without the macro, use fixed 34-cycle latency for all operands, including b == 0.

Verification
REQ-029 SHALL cover: DIVU a=100, b=7 at T -> done at T+34, res=14, zero=0.
REQ-030 SHALL cover: REM a=0xFFFFFFF9, b=2 -> res=0xFFFFFFFF; DIV same operands -> res=0xFFFFFFFD.
REQ-031 SHALL cover: DIV a=0x80000000, b=0xFFFFFFFF -> res=0x80000000; REM same operands -> res=0, zero=1.
REQ-032 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; done at T+2 with EARLY_OUT_EN, else T+34.
REQ-033 SHALL cover: start pulsed at T+5 during busy -> ignored, single done at T+34 with original result.
REQ-034 SHALL cover: rst at T+10 mid-RUN -> next cycle busy=0, res=0, zero=1, and no done pulse.

Source files
------------

// File: rtl/div_unit_if.sv
// Request/response bundle for div_unit: operands and start in, status and result out.
interface div_unit_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic        zero;

  modport master (output start, a, b, op, input busy, done, res, zero);
  modport slave  (input start, a, b, op, output busy, done, res, zero);
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_UNIT_EARLY_OUT_EN skips iteration when b == 0 or |a| < |b|.
//
// state  | meaning
// IDLE   | waiting for start, result registers hold last value
// RUN    | 32 restoring-division iterations
// FIX    | apply sign correction, select quotient or remainder
// DONE   | done pulse, result valid
module div_unit (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q, rem_q, div_q;
  logic        neg_quo_q, neg_rem_q, is_rem_q;
  logic        busy_q, done_q, zero_q;
  logic [31:0] res_q;

  logic        sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] shifted;
  logic        ge;
  logic [31:0] quo_d, rem_d, res_d;

  always_comb begin
    sgn     = ~bus.op[0];
    a_neg   = sgn & bus.a[31];
    b_neg   = sgn & bus.b[31];
    a_mag   = a_neg ? (~bus.a + 32'd1) : bus.a;
    b_mag   = b_neg ? (~bus.b + 32'd1) : bus.b;
    // rem_q[31] set means the shifted partial remainder exceeds 32 bits, so it is >= divisor
    shifted = {rem_q[30:0], quo_q[31]};
    ge      = rem_q[31] | (shifted >= div_q);
    rem_d   = ge ? (shifted - div_q) : shifted;
    quo_d   = {quo_q[30:0], ge};
    if (is_rem_q)
      res_d = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
    else
      res_d = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      div_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= 32'd0;
      zero_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            div_q     <= b_mag;
            neg_quo_q <= sgn & (bus.b != 32'd0) & (bus.a[31] != bus.b[31]);
            neg_rem_q <= a_neg;
            is_rem_q  <= bus.op[1];
            busy_q    <= 1'b1;
            cnt_q     <= 5'd31;
`ifdef DIV_UNIT_EARLY_OUT_EN
            if ((bus.b == 32'd0) || (a_mag < b_mag)) begin
              // Divide-by-zero quotient is all ones; otherwise the quotient is 0 and remainder |a|
              quo_q   <= (bus.b == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
              rem_q   <= a_mag;
              state_q <= S_FIX;
            end else begin
              quo_q   <= a_mag;
              rem_q   <= 32'd0;
              state_q <= S_RUN;
            end
`else
            quo_q   <= a_mag;
            rem_q   <= 32'd0;
            state_q <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          if (cnt_q == 5'd0)
            state_q <= S_FIX;
          else
            cnt_q <= cnt_q - 5'd1;
        end
        S_FIX: begin
          res_q   <= res_d;
          zero_q  <= (res_d == 32'd0);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;
  assign bus.zero = zero_q;

endmodule
